psg_bus_arbiter: RTL and testbench

//  Shares one ym2149 PSG register bus between two requesters (port 0: sound CPU,

---
 rtl/psg_bus_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_psg_bus_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psg_bus_arbiter.sv
// Two-port arbiter for a ym2149 PSG register bus. Each granted request is turned
// into an address latch, an access, and an inactive gap. Ports are served round-robin.
module psg_bus_arbiter #(
   parameter int PHASE_LEN  = 1,
   parameter int GAP_LEN    = 1,
   parameter bit ADDR_CACHE = 1
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       flush,
   input  logic       req0,
   input  logic       we0,
   input  logic [3:0] addr0,
   input  logic [7:0] din0,
   output logic       ack0,
   output logic [7:0] dout0,
   input  logic       req1,
   input  logic       we1,
   input  logic [3:0] addr1,
   input  logic [7:0] din1,
   output logic       ack1,
   output logic [7:0] dout1,
   output logic       psg_bdir,
   output logic       psg_bc,
   output logic [7:0] psg_di,
   input  logic [7:0] psg_do,
   output logic       busy
);

   localparam int CNT_W = $clog2((PHASE_LEN > GAP_LEN ? PHASE_LEN : GAP_LEN) + 1);
   localparam logic [CNT_W-1:0] PH_LAST  = CNT_W'(PHASE_LEN - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_LEN - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADDR = 2'd1;
   localparam logic [1:0] S_ACC  = 2'd2;
   localparam logic [1:0] S_GAP  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             grant_q, grant_d;
   logic             last_q, last_d;
   logic             we_q, we_d;
   logic [3:0]       addr_q, addr_d;
   logic [7:0]       din_q, din_d;
   logic [3:0]       cache_q, cache_d;
   logic             cvld_q, cvld_d;
   logic             bdir_q, bdir_d;
   logic             bc_q, bc_d;
   logic [7:0]       di_q, di_d;
   logic             ack0_q, ack0_d;
   logic             ack1_q, ack1_d;
   logic [7:0]       dout0_q, dout0_d;
   logic [7:0]       dout1_q, dout1_d;
   logic             busy_q, busy_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      grant_d = grant_q;
      last_d  = last_q;
      we_d    = we_q;
      addr_d  = addr_q;
      din_d   = din_q;
      cache_d = cache_q;
      cvld_d  = cvld_q;
      dout0_d = dout0_q;
      dout1_d = dout1_q;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (req0 || req1) begin
               // with both pending, the port not served last wins
               grant_d = (req0 && req1) ? ~last_q : req1;
               last_d  = grant_d;
               we_d    = grant_d ? we1 : we0;
               addr_d  = grant_d ? addr1 : addr0;
               din_d   = grant_d ? din1 : din0;
               state_d = (ADDR_CACHE && cvld_q && cache_q == addr_d) ? S_ACC : S_ADDR;
            end
         end
         S_ADDR: begin
            if (cnt_q == PH_LAST) begin
               state_d = S_ACC;
               cnt_d   = '0;
               cache_d = addr_q;
               cvld_d  = 1'b1;
            end
         end
         S_ACC: begin
            if (cnt_q == PH_LAST) begin
               state_d = S_GAP;
               cnt_d   = '0;
               if (!we_q) begin
                  if (grant_q) dout1_d = psg_do;
                  else         dout0_d = psg_do;
               end
            end
         end
         default: begin
            if (cnt_q == GAP_LAST) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         end
      endcase

      // a flush overrides a cache fill on the same edge
      if (flush) cvld_d = 1'b0;

      // bus outputs are registered from the next state so they align with it
      bdir_d = 1'b0;
      bc_d   = 1'b0;
      di_d   = 8'hFF;
      case (state_d)
         S_ADDR: begin
            bdir_d = 1'b1;
            bc_d   = 1'b1;
            di_d   = {4'h0, addr_d};
         end
         S_ACC: begin
            if (we_d) begin
               bdir_d = 1'b1;
               di_d   = din_d;
            end else begin
               bc_d   = 1'b1;
            end
         end
         default: ;
      endcase
      ack0_d = (state_q == S_ACC) && (state_d == S_GAP) && !grant_q;
      ack1_d = (state_q == S_ACC) && (state_d == S_GAP) && grant_q;
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
         we_q    <= 1'b0;
         addr_q  <= 4'h0;
         din_q   <= 8'h00;
         cache_q <= 4'h0;
         cvld_q  <= 1'b0;
         bdir_q  <= 1'b0;
         bc_q    <= 1'b0;
         di_q    <= 8'hFF;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         dout0_q <= 8'h00;
         dout1_q <= 8'h00;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         cache_q <= cache_d;
         cvld_q  <= cvld_d;
         bdir_q  <= bdir_d;
         bc_q    <= bc_d;
         di_q    <= di_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         dout0_q <= dout0_d;
         dout1_q <= dout1_d;
         busy_q  <= busy_d;
      end
   end

   assign psg_bdir = bdir_q;
   assign psg_bc   = bc_q;
   assign psg_di   = di_q;
   assign ack0     = ack0_q;
   assign ack1     = ack1_q;
   assign dout0    = dout0_q;
   assign dout1    = dout1_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_psg_bus_arbiter.sv
// Bench for psg_bus_arbiter: directed vector table, hand sequences for multi-cycle
// corners, and random traffic against a transaction-level bus-trace model.
module tb_psg_bus_arbiter;

   localparam int P = 1;
   localparam int G = 1;

   logic       CLK = 1'b0, RESET = 1'b1, flush = 1'b0;
   logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [3:0] addr0 = 4'h0, addr1 = 4'h0;
   logic [7:0] din0 = 8'h00, din1 = 8'h00, psg_do = 8'h00;
   logic       ack0, ack1, bdir, bc, busy;
   logic [7:0] dout0, dout1, di;
   logic       t_ack0, t_ack1, t_bdir, t_bc, t_busy;
   logic [7:0] t_dout0, t_dout1, t_di;

   int checks = 0, errors = 0;

   always #5 CLK = ~CLK;

   psg_bus_arbiter #(.PHASE_LEN(P), .GAP_LEN(G), .ADDR_CACHE(1'b1)) dut (
      .CLK(CLK), .RESET(RESET), .flush(flush),
      .req0(req0), .we0(we0), .addr0(addr0), .din0(din0), .ack0(ack0), .dout0(dout0),
      .req1(req1), .we1(we1), .addr1(addr1), .din1(din1), .ack1(ack1), .dout1(dout1),
      .psg_bdir(bdir), .psg_bc(bc), .psg_di(di), .psg_do(psg_do), .busy(busy));

   psg_bus_arbiter #(.PHASE_LEN(3), .GAP_LEN(2), .ADDR_CACHE(1'b1)) dut3 (
      .CLK(CLK), .RESET(RESET), .flush(flush),
      .req0(req0), .we0(we0), .addr0(addr0), .din0(din0), .ack0(t_ack0), .dout0(t_dout0),
      .req1(req1), .we1(we1), .addr1(addr1), .din1(din1), .ack1(t_ack1), .dout1(t_dout1),
      .psg_bdir(t_bdir), .psg_bc(t_bc), .psg_di(t_di), .psg_do(psg_do), .busy(t_busy));

   // bus word: {bdir, bc, di[7:0], ack0, ack1, busy}
   localparam logic [12:0] IDL = {2'b00, 8'hFF, 3'b000};
   localparam logic [12:0] RD  = {2'b01, 8'hFF, 3'b001};
   localparam logic [12:0] GA0 = {2'b00, 8'hFF, 3'b101};
   localparam logic [12:0] GA1 = {2'b00, 8'hFF, 3'b011};
   localparam logic [12:0] GAB = {2'b00, 8'hFF, 3'b001};

   function automatic logic [12:0] fa(input logic [3:0] a);
      return {2'b11, 4'h0, a, 3'b001};
   endfunction
   function automatic logic [12:0] fw(input logic [7:0] d);
      return {2'b10, d, 3'b001};
   endfunction

   function automatic logic [12:0] bus_now();
      return {bdir, bc, di, ack0, ack1, busy};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      logic r0, w0; logic [3:0] a0; logic [7:0] d0;
      logic r1, w1; logic [3:0] a1; logic [7:0] d1;
      logic fl; logic [7:0] pdo; logic [12:0] eb; logic [15:0] ed;
   } vec_t;

   function automatic vec_t mk(input logic r0, w0, input logic [3:0] a0, input logic [7:0] d0,
                               input logic r1, w1, input logic [3:0] a1, input logic [7:0] d1,
                               input logic fl, input logic [7:0] pdo,
                               input logic [12:0] eb, input logic [15:0] ed);
      vec_t v;
      v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
      v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
      v.fl = fl; v.pdo = pdo; v.eb = eb; v.ed = ed;
      return v;
   endfunction

   // ---------------- reference model: each grant expands into a per-cycle trace
   typedef struct packed {
      logic [12:0] bus; logic upd; logic cap; logic port; logic [3:0] addr;
   } cyc_t;

   cyc_t       mq[$];
   cyc_t       cur;
   logic       m_last, m_cv;
   logic [3:0] m_ca;
   logic [7:0] m_dout[2];
   logic       m_gr[2];

   task automatic m_reset();
      mq.delete();
      cur = '0; cur.bus = IDL;
      m_last = 1'b1; m_cv = 1'b0; m_ca = 4'h0;
      m_dout[0] = 8'h00; m_dout[1] = 8'h00;
      m_gr[0] = 1'b0; m_gr[1] = 1'b0;
   endtask

   task automatic m_edge();
      cyc_t e; logic p, w, hit; logic [3:0] a; logic [7:0] d;
      if (cur.cap) m_dout[cur.port] = psg_do;
      if (mq.size() == 0 && (req0 || req1)) begin
         p = (req0 && req1) ? ~m_last : req1;
         m_last = p; m_gr[p] = 1'b1;
         w = p ? we1 : we0; a = p ? addr1 : addr0; d = p ? din1 : din0;
         hit = m_cv && (m_ca == a);
         if (!hit)
            for (int i = 0; i < P; i++) begin
               e = '0; e.bus = fa(a); e.upd = (i == P - 1); e.addr = a; mq.push_back(e);
            end
         for (int i = 0; i < P; i++) begin
            e = '0; e.bus = w ? fw(d) : RD; e.cap = !w && (i == P - 1); e.port = p;
            mq.push_back(e);
         end
         for (int i = 0; i < G; i++) begin
            e = '0; e.bus = GAB;
            if (i == 0) e.bus = p ? GA1 : GA0;
            mq.push_back(e);
         end
         e = '0; e.bus = IDL; mq.push_back(e);
      end
      if (cur.upd) begin m_ca = cur.addr; m_cv = 1'b1; end
      if (flush) m_cv = 1'b0;
      if (mq.size() != 0) cur = mq.pop_front();
      else begin cur = '0; cur.bus = IDL; end
   endtask

   task automatic rnd_fields(output logic w, output logic [3:0] a, output logic [7:0] d);
      w = 1'($urandom_range(1));
      a = 4'($urandom_range(3));
      d = 8'($urandom);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RESET = 1'b1; req0 = 1'b0; req1 = 1'b0; flush = 1'b0;
      @(negedge CLK);
      RESET = 1'b0;
   endtask

   vec_t        tbl[32];
   logic [12:0] exp3[9];
   int          acks[$];
   int          nack;

   initial begin
      tbl[0]  = mk(1,1,4'h7,8'h38, 0,0,4'h0,8'h00, 0,8'h00, fa(4'h7),   16'h0000);
      tbl[1]  = mk(1,1,4'h7,8'h38, 0,0,4'h0,8'h00, 0,8'h00, fw(8'h38),  16'h0000);
      tbl[2]  = mk(1,1,4'h7,8'h38, 0,0,4'h0,8'h00, 0,8'h00, GA0,        16'h0000);
      tbl[3]  = mk(0,1,4'h7,8'h38, 0,0,4'h0,8'h00, 0,8'h00, IDL,        16'h0000);
      tbl[4]  = mk(0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 0,8'h00, IDL,        16'h0000);
      tbl[5]  = mk(0,0,4'h0,8'h00, 1,0,4'hE,8'h00, 0,8'h00, fa(4'hE),   16'h0000);
      tbl[6]  = mk(0,0,4'h0,8'h00, 1,0,4'hE,8'h00, 0,8'h00, RD,         16'h0000);
      tbl[7]  = mk(0,0,4'h0,8'h00, 1,0,4'hE,8'h00, 0,8'hA5, GA1,        16'h00A5);
      tbl[8]  = mk(0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 0,8'h00, IDL,        16'h00A5);
      tbl[9]  = mk(1,1,4'h8,8'h11, 0,0,4'h0,8'h00, 0,8'h00, fa(4'h8),   16'h00A5);
      tbl[10] = mk(1,1,4'h8,8'h11, 0,0,4'h0,8'h00, 0,8'h00, fw(8'h11),  16'h00A5);
      tbl[11] = mk(1,1,4'h8,8'h11, 0,0,4'h0,8'h00, 0,8'h00, GA0,        16'h00A5);
      tbl[12] = mk(0,1,4'h8,8'h11, 0,0,4'h0,8'h00, 0,8'h00, IDL,        16'h00A5);
      tbl[13] = mk(1,1,4'h8,8'h22, 0,0,4'h0,8'h00, 0,8'h00, fw(8'h22),  16'h00A5);
      tbl[14] = mk(1,1,4'h8,8'h22, 0,0,4'h0,8'h00, 0,8'h00, GA0,        16'h00A5);
      tbl[15] = mk(0,1,4'h8,8'h22, 0,0,4'h0,8'h00, 1,8'h00, IDL,        16'h00A5);
      tbl[16] = mk(1,1,4'h8,8'h33, 0,0,4'h0,8'h00, 0,8'h00, fa(4'h8),   16'h00A5);
      tbl[17] = mk(1,1,4'h8,8'h33, 0,0,4'h0,8'h00, 0,8'h00, fw(8'h33),  16'h00A5);
      tbl[18] = mk(1,1,4'h8,8'h33, 0,0,4'h0,8'h00, 0,8'h00, GA0,        16'h00A5);
      tbl[19] = mk(0,1,4'h8,8'h33, 0,0,4'h0,8'h00, 0,8'h00, IDL,        16'h00A5);
      tbl[20] = mk(1,1,4'h9,8'h44, 0,0,4'h0,8'h00, 0,8'h00, fa(4'h9),   16'h00A5);
      tbl[21] = mk(1,1,4'h9,8'h44, 0,0,4'h0,8'h00, 1,8'h00, fw(8'h44),  16'h00A5);
      tbl[22] = mk(1,1,4'h9,8'h44, 0,0,4'h0,8'h00, 0,8'h00, GA0,        16'h00A5);
      tbl[23] = mk(0,1,4'h9,8'h44, 0,0,4'h0,8'h00, 0,8'h00, IDL,        16'h00A5);
      tbl[24] = mk(1,1,4'h9,8'h55, 0,0,4'h0,8'h00, 0,8'h00, fa(4'h9),   16'h00A5);
      tbl[25] = mk(1,1,4'h9,8'h55, 0,0,4'h0,8'h00, 0,8'h00, fw(8'h55),  16'h00A5);
      tbl[26] = mk(1,1,4'h9,8'h55, 0,0,4'h0,8'h00, 0,8'h00, GA0,        16'h00A5);
      tbl[27] = mk(0,1,4'h9,8'h55, 0,0,4'h0,8'h00, 0,8'h00, IDL,        16'h00A5);
      tbl[28] = mk(1,0,4'h3,8'h00, 0,0,4'h0,8'h00, 0,8'h00, fa(4'h3),   16'h00A5);
      tbl[29] = mk(1,0,4'h3,8'h00, 0,0,4'h0,8'h00, 0,8'h00, RD,         16'h00A5);
      tbl[30] = mk(1,0,4'h3,8'h00, 0,0,4'h0,8'h00, 0,8'h3C, GA0,        16'h3CA5);
      tbl[31] = mk(0,0,4'h3,8'h00, 0,0,4'h0,8'h00, 0,8'h00, IDL,        16'h3CA5);

      // reset state
      @(negedge CLK);
      chk("rst_bus", 32'(bus_now()), 32'(IDL));
      chk("rst_dout", {16'h0, dout0, dout1}, 32'h0);
      RESET = 1'b0;

      // directed vector table
      for (int i = 0; i < 32; i++) begin
         req0 = tbl[i].r0; we0 = tbl[i].w0; addr0 = tbl[i].a0; din0 = tbl[i].d0;
         req1 = tbl[i].r1; we1 = tbl[i].w1; addr1 = tbl[i].a1; din1 = tbl[i].d1;
         flush = tbl[i].fl; psg_do = tbl[i].pdo;
         @(negedge CLK);
         chk($sformatf("vec%0d_bus", i), 32'(bus_now()), 32'(tbl[i].eb));
         chk($sformatf("vec%0d_dout", i), {16'h0, dout0, dout1}, {16'h0, tbl[i].ed});
      end
      flush = 1'b0; psg_do = 8'h00;

      // long phases on the second instance
      for (int k = 0; k < 3; k++) exp3[k] = fa(4'h5);
      for (int k = 3; k < 6; k++) exp3[k] = fw(8'h5A);
      exp3[6] = GA0; exp3[7] = GAB; exp3[8] = IDL;
      do_reset();
      req0 = 1'b1; we0 = 1'b1; addr0 = 4'h5; din0 = 8'h5A;
      for (int k = 0; k < 9; k++) begin
         @(negedge CLK);
         chk($sformatf("long%0d_bus", k), 32'({t_bdir, t_bc, t_di, t_ack0, t_ack1, t_busy}),
             32'(exp3[k]));
         if (k == 6) req0 = 1'b0;
      end

      // round robin with both ports held
      do_reset();
      req0 = 1'b1; we0 = 1'b1; addr0 = 4'h1; din0 = 8'h01;
      req1 = 1'b1; we1 = 1'b1; addr1 = 4'h2; din1 = 8'h02;
      for (int k = 0; k < 16; k++) begin
         @(negedge CLK);
         if (ack0) acks.push_back(0);
         if (ack1) acks.push_back(1);
      end
      req0 = 1'b0; req1 = 1'b0;
      chk("rr_count", acks.size(), 4);
      for (int i = 0; i < acks.size() && i < 4; i++)
         chk($sformatf("rr_order%0d", i), acks[i], i % 2);

      // reset during the access phase of a write
      do_reset();
      req0 = 1'b1; we0 = 1'b1; addr0 = 4'h3; din0 = 8'h77;
      @(negedge CLK);
      @(negedge CLK);
      chk("rm_access", 32'(bus_now()), 32'(fw(8'h77)));
      #1 RESET = 1'b1;
      #1 chk("rm_release", 32'(bus_now()), 32'(IDL));
      @(negedge CLK);
      RESET = 1'b0; req0 = 1'b0;
      nack = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         if (ack0 || ack1) nack++;
      end
      chk("rm_noack", nack, 0);
      req0 = 1'b1; din0 = 8'h78;
      @(negedge CLK);
      chk("rm_readdr", 32'(bus_now()), 32'(fa(4'h3)));
      @(negedge CLK);
      @(negedge CLK);
      chk("rm_ack", 32'(bus_now()), 32'(GA0));
      req0 = 1'b0;

      // random traffic against the model
      do_reset();
      m_reset();
      for (int c = 0; c < 3000; c++) begin
         @(posedge CLK);
         m_edge();
         @(negedge CLK);
         chk($sformatf("rnd%0d_bus", c), 32'(bus_now()), 32'(cur.bus));
         chk($sformatf("rnd%0d_dout", c), {16'h0, dout0, dout1}, {16'h0, m_dout[0], m_dout[1]});
         psg_do = 8'($urandom);
         flush = ($urandom_range(9) == 0);
         if (cur.bus[2]) m_gr[0] = 1'b0;
         if (cur.bus[1]) m_gr[1] = 1'b0;
         if (req0) begin
            if (cur.bus[2]) begin
               if ($urandom_range(1) == 1) rnd_fields(we0, addr0, din0);
               else req0 = 1'b0;
            end else if (!m_gr[0] && $urandom_range(15) == 0) req0 = 1'b0;
         end else if ($urandom_range(2) == 0) begin
            req0 = 1'b1; rnd_fields(we0, addr0, din0);
         end
         if (req1) begin
            if (cur.bus[1]) begin
               if ($urandom_range(1) == 1) rnd_fields(we1, addr1, din1);
               else req1 = 1'b0;
            end else if (!m_gr[1] && $urandom_range(15) == 0) req1 = 1'b0;
         end else if ($urandom_range(2) == 0) begin
            req1 = 1'b1; rnd_fields(we1, addr1, din1);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
